la_aopipe: RTL

- Parametrised, pipelined successor to the single-bit ao21 cell.
- Computes a DW-bit wide N-input AND term OR'd with a bypass term: z = (a0 & a1 & ... & a(N-1)) | b.
- Result is carried through STAGES register stages with a valid/ready handshake and full backpressure.
- Used in stdlib datapaths where wide AO logic must be retimed into a pipelined stream.

---
 rtl/la_aopipe.sv | 92 +++++++++
 1 files changed

// File: rtl/la_aopipe.sv
// la_aopipe: DW-bit N-input AND OR'd with b, carried through a STAGES-deep valid/ready pipeline.
// Define LA_AOPIPE_CNT_EN to add the saturating beat_cnt output-transfer counter.
module la_aopipe #(
    parameter     PROP   = "DEFAULT",
    parameter int DW     = 8,
    parameter int N      = 2,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a,
    input  logic [DW-1:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   z
`ifdef LA_AOPIPE_CNT_EN
    ,
    output logic [15:0]     beat_cnt
`endif
);

    logic [DW-1:0]     w_and;
    logic [DW-1:0]     w_f;
    logic [STAGES-1:0] r_v;
    logic [DW-1:0]     r_d [STAGES];
    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_src_v;
    logic [DW-1:0]     w_src_d [STAGES];

    always_comb begin
        w_and = '1;
        for (int i = 0; i < N; i++) begin
            w_and = w_and & a[i*DW +: DW];
        end
        w_f = w_and | b;
    end

    // A stage can load whenever any stage at or below it has a hole, or the output drains.
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_ld
        assign w_ld[k] = out_ready | ~(&r_v[STAGES-1:k]);
    end

    always_comb begin
        w_src_v[0] = in_valid;
        w_src_d[0] = w_f;
        for (int s = 1; s < STAGES; s++) begin
            w_src_v[s] = r_v[s-1];
            w_src_d[s] = r_d[s-1];
        end
    end

    // Data only moves with a valid beat, so z stays put while bubbles pass.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_d[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_ld[s]) begin
                    r_v[s] <= w_src_v[s];
                    if (w_src_v[s]) begin
                        r_d[s] <= w_src_d[s];
                    end
                end
            end
        end
    end

    assign in_ready  = w_ld[0];
    assign out_valid = r_v[STAGES-1];
    assign z         = r_d[STAGES-1];

`ifdef LA_AOPIPE_CNT_EN
    logic [15:0] r_beat_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_beat_cnt <= '0;
        end else if (out_valid && out_ready && (r_beat_cnt != 16'hFFFF)) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule
